// File: rtl/rb_apb_pkg.sv
// Shared types and default widths for the register-bus APB initiator.
package rb_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_mst_state_e;

    localparam int unsigned RB_APB_ADDR_W = 8;
    localparam int unsigned RB_APB_DATA_W = 32;

endpackage

// File: rtl/rb_apb_master_if.sv
// Request/response channels plus APB bus; master = bridge side, slave = requester/APB side.
interface rb_apb_master_if import rb_apb_pkg::*; #(
    parameter int unsigned ADDR_W = RB_APB_ADDR_W,
    parameter int unsigned DATA_W = RB_APB_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic              pslverr;
    logic [DATA_W-1:0] prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
               pready, pslverr, prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
               pready, pslverr, prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/rb_apb_tmo_cnt.sv
// Saturating PREADY wait counter; o_expired flags the limit, never set when TIMEOUT=0.
module rb_apb_tmo_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/rb_apb_master.sv
// Single-request APB initiator: SETUP/ACCESS per request, bounded PREADY wait,
// registered response held until consumed.
module rb_apb_master import rb_apb_pkg::*; #(
    parameter int unsigned ADDR_W  = RB_APB_ADDR_W,
    parameter int unsigned DATA_W  = RB_APB_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input logic             pclk,
    input logic             presetn,
    rb_apb_master_if.master bus
);

    apb_mst_state_e    r_state;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;

    logic w_req_ready;
    logic w_accept;
    logic w_cnt_clear;
    logic w_cnt_en;
    logic w_expired;

    // A pending response may be retired and replaced in the same cycle.
    assign w_req_ready = (r_state == ST_IDLE) || ((r_state == ST_RESP) && bus.rsp_ready);
    assign w_accept    = w_req_ready && bus.req_valid;
    assign w_cnt_clear = (r_state == ST_SETUP);
    assign w_cnt_en    = (r_state == ST_ACCESS) && !bus.pready;

    rb_apb_tmo_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo_cnt (
        .i_clk     (pclk),
        .i_rst_n   (presetn),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state       <= ST_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_paddr  <= bus.req_addr;
                r_pwrite <= bus.req_write;
                r_pwdata <= bus.req_write ? bus.req_wdata : '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_psel  <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.pready) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? '0 : bus.prdata;
                        r_rsp_err     <= bus.pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= ST_RESP;
                    end else if (w_expired) begin
                        // Abort drops psel mid-wait; slaves are expected to tolerate it.
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (bus.req_valid) begin
                            r_psel  <= 1'b1;
                            r_state <= ST_SETUP;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.pwrite      = r_pwrite;
    assign bus.paddr       = r_paddr;
    assign bus.pwdata      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_rb_apb_master.sv
// Directed bench for rb_apb_master with TIMEOUT=4; expected values are hand-computed.
module tb_rb_apb_master;

    localparam int unsigned TMO = 4;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    rb_apb_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    rb_apb_master #(
        .ADDR_W  (8),
        .DATA_W  (32),
        .TIMEOUT (TMO)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    // {psel, penable, pwrite, rsp_valid, req_ready}
    logic [4:0]  ctl;
    // {rsp_err, rsp_timeout, rsp_rdata}
    logic [33:0] rsp;
    assign ctl = {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.req_ready};
    assign rsp = {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata};

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [7:0] a, input logic [31:0] d);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    task automatic test_reset();
        presetn       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        bus.prdata    = '0;
        step();
        step();
        checks++;
        if (ctl !== 5'b00001) begin
            failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 5'b00001);
        end
        checks++;
        if ({bus.paddr, bus.pwdata} !== 40'h0) begin
            failures++; $display("FAIL reset_addr_data got=%h exp=%h", {bus.paddr, bus.pwdata}, 40'h0);
        end
        checks++;
        if (rsp !== 34'h0) begin
            failures++; $display("FAIL reset_rsp got=%h exp=%h", rsp, 34'h0);
        end
        presetn = 1'b1;
        step();
    endtask

    task automatic test_write();
        drive_req(1'b1, 8'h10, 32'hDEADBEEF);
        bus.pready    = 1'b1;
        bus.rsp_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'h0;
        checks++;
        if ({ctl, bus.paddr, bus.pwdata} !== {5'b10100, 8'h10, 32'hDEADBEEF}) begin
            failures++; $display("FAIL write_setup got=%h exp=%h", {ctl, bus.paddr, bus.pwdata}, {5'b10100, 8'h10, 32'hDEADBEEF});
        end
        step();
        checks++;
        if ({ctl, bus.pwdata} !== {5'b11100, 32'hDEADBEEF}) begin
            failures++; $display("FAIL write_access got=%h exp=%h", {ctl, bus.pwdata}, {5'b11100, 32'hDEADBEEF});
        end
        step();
        checks++;
        if ({ctl, rsp} !== {5'b00111, 34'h0}) begin
            failures++; $display("FAIL write_resp got=%h exp=%h", {ctl, rsp}, {5'b00111, 34'h0});
        end
        step();
        checks++;
        if ({ctl, bus.paddr} !== {5'b00101, 8'h10}) begin
            failures++; $display("FAIL write_idle got=%h exp=%h", {ctl, bus.paddr}, {5'b00101, 8'h10});
        end
    endtask

    task automatic test_read_wait();
        drive_req(1'b0, 8'h24, 32'hFFFFFFFF);
        bus.pready = 1'b0;
        step();
        bus.req_valid = 1'b0;
        checks++;
        if ({ctl, bus.paddr, bus.pwdata} !== {5'b10000, 8'h24, 32'h0}) begin
            failures++; $display("FAIL read_setup got=%h exp=%h", {ctl, bus.paddr, bus.pwdata}, {5'b10000, 8'h24, 32'h0});
        end
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus.pready = 1'b1;
                bus.prdata = 32'h12345678;
            end
            checks++;
            if ({ctl, bus.paddr} !== {5'b11000, 8'h24}) begin
                failures++; $display("FAIL read_access[%0d] got=%h exp=%h", i, {ctl, bus.paddr}, {5'b11000, 8'h24});
            end
            step();
        end
        checks++;
        if ({ctl, rsp} !== {5'b00011, 2'b00, 32'h12345678}) begin
            failures++; $display("FAIL read_resp got=%h exp=%h", {ctl, rsp}, {5'b00011, 2'b00, 32'h12345678});
        end
        bus.pready = 1'b0;
        bus.prdata = 32'h0;
        step();
    endtask

    task automatic test_slverr();
        drive_req(1'b0, 8'h30, 32'h0);
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        bus.prdata  = 32'hAAAA5555;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        checks++;
        if ({ctl, rsp} !== {5'b00011, 2'b10, 32'hAAAA5555}) begin
            failures++; $display("FAIL slverr_resp got=%h exp=%h", {ctl, rsp}, {5'b00011, 2'b10, 32'hAAAA5555});
        end
        bus.pslverr = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        drive_req(1'b0, 8'h40, 32'h0);
        bus.pready = 1'b0;
        bus.prdata = 32'hFFFFFFFF;
        step();
        bus.req_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ctl !== 5'b11000) begin
                failures++; $display("FAIL tmo_access[%0d] got=%b exp=%b", i, ctl, 5'b11000);
            end
            step();
        end
        checks++;
        if ({ctl, rsp} !== {5'b00011, 2'b11, 32'h0}) begin
            failures++; $display("FAIL tmo_resp got=%h exp=%h", {ctl, rsp}, {5'b00011, 2'b11, 32'h0});
        end
        step();
        drive_req(1'b1, 8'h44, 32'h0BADF00D);
        bus.pready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        checks++;
        if ({ctl, bus.paddr, rsp} !== {5'b00111, 8'h44, 34'h0}) begin
            failures++; $display("FAIL tmo_next got=%h exp=%h", {ctl, bus.paddr, rsp}, {5'b00111, 8'h44, 34'h0});
        end
        step();
    endtask

    task automatic test_rsp_hold();
        drive_req(1'b0, 8'h50, 32'h0);
        bus.pready    = 1'b1;
        bus.prdata    = 32'hCAFEF00D;
        bus.rsp_ready = 1'b0;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            bus.prdata = 32'h1000 + i;
            bus.pready = i[0];
            #1;
            checks++;
            if ({ctl, rsp} !== {5'b00010, 2'b00, 32'hCAFEF00D}) begin
                failures++; $display("FAIL hold[%0d] got=%h exp=%h", i, {ctl, rsp}, {5'b00010, 2'b00, 32'hCAFEF00D});
            end
            step();
        end
        bus.rsp_ready = 1'b1;
        drive_req(1'b1, 8'h54, 32'h11223344);
        #1;
        checks++;
        if (ctl !== 5'b00011) begin
            failures++; $display("FAIL hold_accept got=%b exp=%b", ctl, 5'b00011);
        end
        step();
        bus.req_valid = 1'b0;
        checks++;
        if ({ctl, bus.paddr, bus.pwdata} !== {5'b10100, 8'h54, 32'h11223344}) begin
            failures++; $display("FAIL hold_setup got=%h exp=%h", {ctl, bus.paddr, bus.pwdata}, {5'b10100, 8'h54, 32'h11223344});
        end
        bus.pready = 1'b1;
        step();
        step();
        checks++;
        if ({ctl, rsp} !== {5'b00111, 34'h0}) begin
            failures++; $display("FAIL hold_next_resp got=%h exp=%h", {ctl, rsp}, {5'b00111, 34'h0});
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive_req(1'b0, 8'h60, 32'h0);
        bus.pready    = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        checks++;
        if (ctl !== 5'b11000) begin
            failures++; $display("FAIL rstmid_access got=%b exp=%b", ctl, 5'b11000);
        end
        presetn = 1'b0;
        step();
        checks++;
        if ({ctl, bus.paddr} !== {5'b00001, 8'h00}) begin
            failures++; $display("FAIL rstmid_reset got=%h exp=%h", {ctl, bus.paddr}, {5'b00001, 8'h00});
        end
        presetn    = 1'b1;
        bus.pready = 1'b1;
        step();
        step();
        checks++;
        if (ctl !== 5'b00001) begin
            failures++; $display("FAIL rstmid_noresp got=%b exp=%b", ctl, 5'b00001);
        end
        drive_req(1'b1, 8'h68, 32'h55AA55AA);
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        checks++;
        if ({ctl, bus.paddr, rsp} !== {5'b00111, 8'h68, 34'h0}) begin
            failures++; $display("FAIL rstmid_next got=%h exp=%h", {ctl, bus.paddr, rsp}, {5'b00111, 8'h68, 34'h0});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_rsp_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
